// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } ifq_state_e;

  localparam int WORD_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of fetched {instr, pc} entries; Flush has priority over Push and Pop.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Flush,
  input  logic                     Push,
  input  ifq_entry_t               PushData,
  input  logic                     Pop,
  output ifq_entry_t               Head,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifq_entry_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else begin
      if (Push) begin
        mem[wr_ptr] <= PushData;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (Pop) rd_ptr <= rd_ptr + 1'b1;
      Count <= Count + CW'(Push) - CW'(Pop);
    end
  end

  assign Head  = mem[rd_ptr];
  assign Full  = (Count == CW'(DEPTH));
  assign Empty = (Count == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch engine: one outstanding req/ack read, entries queued for decode.
// Optional same-cycle ack-to-decode bypass when IFQ_BYPASS_EN is defined.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Redirect,
  input  logic [31:0] PCIn,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  input  logic        InstrReady,
  output ifq_state_e  DbgState
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_e    state;
  ifq_state_e    state_nxt;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          ack_ok;
  ifq_entry_t    head;
  ifq_entry_t    ack_entry;

  // Handshakes: a read is outstanding while MemReq=1 and completes on the
  // single-cycle MemAck; a queue entry transfers to decode when
  // InstrValid && InstrReady are both high at a rising edge of Clk.
  assign ack_ok    = (state == REQ) && MemAck && !Redirect;
  assign ack_entry = '{instr: MemData, pc: fetch_pc};
  assign pop       = !empty && InstrReady;

`ifdef IFQ_BYPASS_EN
  logic byp;
  assign byp        = ack_ok && empty;
  assign InstrValid = !empty || byp;
  assign Instr      = byp ? MemData  : head.instr;
  assign InstrPC    = byp ? fetch_pc : head.pc;
  assign push       = ack_ok && !(byp && InstrReady);
`else
  assign InstrValid = !empty;
  assign Instr      = head.instr;
  assign InstrPC    = head.pc;
  assign push       = ack_ok;
`endif

  assign count_after = count + CW'(push) - CW'(pop);
  assign MemReq      = (state == REQ);
  assign MemAddr     = fetch_pc;
  assign DbgState    = state;

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk      (Clk),
    .Reset    (Reset),
    .Flush    (Redirect),
    .Push     (push),
    .PushData (ack_entry),
    .Pop      (pop),
    .Head     (head),
    .Full     (full),
    .Empty    (empty),
    .Count    (count)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_VECTOR;
    end else begin
      state <= state_nxt;
      if (Redirect)    fetch_pc <= word_align(PCIn);
      else if (ack_ok) fetch_pc <= fetch_pc + 32'(WORD_BYTES);
    end
  end

  // A redirect flushes the queue, so IDLE may always restart fetch then.
  // An ack in DRAIN retires the owed response even if a redirect coincides.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!full || Redirect) state_nxt = REQ;
      REQ: begin
        if (Redirect)    state_nxt = MemAck ? IDLE : DRAIN;
        else if (MemAck) state_nxt = (count_after < CW'(DEPTH)) ? REQ : IDLE;
      end
      DRAIN:   if (MemAck) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
